// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator with stall, exception entry/return and circular return-address stack.
//   clk, rst (async, active-high)
//   stall, exception, pc_control[2:0], jmp_addr[25:0], branch_offset[15:0], reg_addr[AW-1:0]
//   pc, seq_pc, epc, ras_top, ras_count, ras_empty
module pc_unit #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
  parameter int          RAS_DEPTH    = 4,
  localparam int         PW           = $clog2(RAS_DEPTH),
  localparam int         CW           = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  exception,
  input  logic [2:0]            pc_control,
  input  logic [25:0]           jmp_addr,
  input  logic [15:0]           branch_offset,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] seq_pc,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [ADDR_WIDTH-1:0] ras_top,
  output logic [CW-1:0]         ras_count,
  output logic                  ras_empty
);
  localparam logic [ADDR_WIDTH-1:0] RV = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] EV = ADDR_WIDTH'(EXC_VECTOR);
  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]         ptr;
  logic [ADDR_WIDTH-1:0] j_target, br_target, next_pc;
  logic                  push, pop, full;
  assign seq_pc    = pc + ADDR_WIDTH'(4);
  assign ras_empty = ras_count == '0;
  assign full      = ras_count == CW'(RAS_DEPTH);
  assign ras_top   = ras_empty ? '0 : ras[ptr];
  assign j_target  = {seq_pc[ADDR_WIDTH-1:28], jmp_addr, 2'b00};
  assign br_target = seq_pc + {{(ADDR_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign push      = pc_control == 3'b100 || pc_control == 3'b101;
  // RET on an empty stack falls back to reg_addr and must not move the pointer
  assign pop       = pc_control == 3'b110 && !ras_empty;
  always_comb begin
    next_pc = seq_pc;
    case (pc_control)
      3'b001, 3'b100: next_pc = j_target;
      3'b010, 3'b101: next_pc = reg_addr;
      3'b011:         next_pc = br_target;
      3'b110:         next_pc = ras_empty ? reg_addr : ras_top;
      3'b111:         next_pc = epc;
      default:        next_pc = seq_pc;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RV;
      epc       <= '0;
      ptr       <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (exception) begin
      epc <= pc;
      pc  <= EV;
    end else if (!stall) begin
      pc <= next_pc;
      if (push) begin
        // when full the write lands on the oldest slot, giving overwrite-oldest for free
        ras[ptr + PW'(1)] <= seq_pc;
        ptr               <= ptr + PW'(1);
        ras_count         <= full ? ras_count : ras_count + CW'(1);
      end else if (pop) begin
        ptr       <= ptr - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end
endmodule
